// File: rtl/i2s_rx_10xe_deser_if.sv
// AXI-Stream-style sample port of the I2S receiver.
// The master drives the payload and valid signals, and the slave returns ready.
interface i2s_rx_10xe_deser_if #(
  parameter int unsigned DATA_WIDTH = 24
) ();
  logic [DATA_WIDTH-1:0] m_axis_tdata;
  logic                  m_axis_tid;
  logic                  m_axis_tvalid;
  logic                  m_axis_tready;

  modport master (
    output m_axis_tdata,
    output m_axis_tid,
    output m_axis_tvalid,
    input  m_axis_tready
  );

  modport slave (
    input  m_axis_tdata,
    input  m_axis_tid,
    input  m_axis_tvalid,
    output m_axis_tready
  );
endinterface

// File: rtl/i2s_rx_10xe_deser.sv
// I2S receiver: oversamples sclk/lrclk/sdata in the aud_mclk domain, recovers framing and
// pushes each completed {channel, sample} into a 2-entry FIFO drained over a valid/ready port.
module i2s_rx_10xe_deser #(
  parameter int unsigned DATA_WIDTH  = 24,
  parameter int unsigned SLOT_WIDTH  = 32,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                       aud_mclk,
  input  logic                       aud_mrst,
  input  logic                       rx_enable,
  input  logic                       sclk_in,
  input  logic                       lrclk_in,
  input  logic                       sdata_0_in,
  input  logic                       err_clr,
  i2s_rx_10xe_deser_if.master        m_axis,
  output logic                       overflow,
  output logic                       frame_err,
  output logic                       irq
);

  localparam int unsigned RC_W = 6;
  localparam logic [RC_W-1:0] RC_MAX  = RC_W'(63);
  localparam logic [RC_W-1:0] RC_ONE  = RC_W'(1);
  localparam logic [RC_W-1:0] RC_MSB  = RC_W'(2);
  localparam logic [RC_W-1:0] RC_LAST = RC_W'(DATA_WIDTH + 1);
  localparam logic [RC_W-1:0] RC_SLOT = RC_W'(SLOT_WIDTH);

  typedef struct packed {
    logic                  id;
    logic [DATA_WIDTH-1:0] data;
  } beat_t;

  typedef enum logic [1:0] {
    ST_DISABLED  = 2'd0,
    ST_WAIT_SYNC = 2'd1,
    ST_RUN       = 2'd2
  } state_t;

  logic [SYNC_STAGES-1:0] r_sclk_sync;
  logic [SYNC_STAGES-1:0] r_ws_sync;
  logic [SYNC_STAGES-1:0] r_sd_sync;
  logic                   r_sclk_prev;
  logic                   r_ws_prev;
  logic                   r_ws_seen;
  logic [RC_W-1:0]        r_rc;
  logic                   r_chan;
  logic [DATA_WIDTH-1:0]  r_shift;
  state_t                 r_state;
  beat_t                  r_head;
  beat_t                  r_tail;
  logic [1:0]             r_cnt;
  logic                   r_valid;
  logic                   r_overflow;
  logic                   r_frame_err;
  logic                   r_irq;

  logic                   w_sclk_s;
  logic                   w_ws_s;
  logic                   w_sd_s;
  logic                   w_rise;
  logic                   w_ws_chg;
  logic [RC_W-1:0]        w_rc_next;
  logic                   w_chan_next;
  logic [DATA_WIDTH-1:0]  w_shift_next;
  state_t                 w_state_next;
  logic                   w_push;
  logic                   w_pop;
  logic                   w_frame_evt;
  logic                   w_ovf_evt;
  beat_t                  w_new;
  beat_t                  w_head_next;
  beat_t                  w_tail_next;
  logic [1:0]             w_cnt_next;

  assign w_sclk_s = r_sclk_sync[SYNC_STAGES-1];
  assign w_ws_s   = r_ws_sync[SYNC_STAGES-1];
  assign w_sd_s   = r_sd_sync[SYNC_STAGES-1];
  assign w_rise   = w_sclk_s & ~r_sclk_prev;
  // A ws change only counts once a ws value has been sampled since reset.
  assign w_ws_chg = w_rise & r_ws_seen & (w_ws_s != r_ws_prev);
  assign w_pop    = r_valid & m_axis.m_axis_tready;

  // Synchronizers and the rise-edge history.
  always_ff @(posedge aud_mclk or posedge aud_mrst) begin
    if (aud_mrst) begin
      r_sclk_sync <= '0;
      r_ws_sync   <= '0;
      r_sd_sync   <= '0;
      r_sclk_prev <= 1'b0;
      r_ws_prev   <= 1'b0;
      r_ws_seen   <= 1'b0;
    end else begin
      r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], sclk_in};
      r_ws_sync   <= {r_ws_sync[SYNC_STAGES-2:0], lrclk_in};
      r_sd_sync   <= {r_sd_sync[SYNC_STAGES-2:0], sdata_0_in};
      r_sclk_prev <= w_sclk_s;
      if (w_rise) begin
        r_ws_prev <= w_ws_s;
        r_ws_seen <= 1'b1;
      end
    end
  end

  // Rise counter, channel tag and MSB-first shift register.
  always_comb begin
    w_rc_next    = r_rc;
    w_chan_next  = r_chan;
    w_shift_next = r_shift;
    if (w_rise) begin
      if (w_ws_chg) begin
        w_rc_next   = RC_ONE;
        w_chan_next = w_ws_s;
      end else if (r_rc != RC_MAX) begin
        w_rc_next = r_rc + RC_ONE;
      end
      if ((w_rc_next >= RC_MSB) && (w_rc_next <= RC_LAST)) begin
        w_shift_next = {r_shift[DATA_WIDTH-2:0], w_sd_s};
      end
    end
  end

  always_ff @(posedge aud_mclk or posedge aud_mrst) begin
    if (aud_mrst) begin
      r_rc    <= '0;
      r_chan  <= 1'b0;
      r_shift <= '0;
    end else begin
      r_rc    <= w_rc_next;
      r_chan  <= w_chan_next;
      r_shift <= w_shift_next;
    end
  end

  always_ff @(posedge aud_mclk or posedge aud_mrst) begin
    if (aud_mrst) begin
      r_state <= ST_DISABLED;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Capture FSM: next state, push strobe and frame-length check.
  always_comb begin
    w_state_next = r_state;
    w_push       = 1'b0;
    w_frame_evt  = 1'b0;
    case (r_state)
      ST_DISABLED: begin
        if (rx_enable) w_state_next = ST_WAIT_SYNC;
      end
      ST_WAIT_SYNC: begin
        if (w_ws_chg) w_state_next = ST_RUN;
      end
      ST_RUN: begin
        if (w_ws_chg && (r_rc != RC_SLOT)) w_frame_evt = 1'b1;
        if (w_rise && (w_rc_next == RC_LAST)) w_push = 1'b1;
      end
      default: w_state_next = ST_DISABLED;
    endcase
    if (!rx_enable) begin
      w_state_next = ST_DISABLED;
      w_push       = 1'b0;
      w_frame_evt  = 1'b0;
    end
  end

  // Two-entry FIFO kept as head/tail registers so the port is driven straight from flops.
  always_comb begin
    w_new       = '{id: w_chan_next, data: w_shift_next};
    w_head_next = r_head;
    w_tail_next = r_tail;
    w_cnt_next  = r_cnt;
    w_ovf_evt   = 1'b0;
    case ({w_push, w_pop})
      2'b10: begin
        if (r_cnt == 2'd0) begin
          w_head_next = w_new;
          w_cnt_next  = 2'd1;
        end else if (r_cnt == 2'd1) begin
          w_tail_next = w_new;
          w_cnt_next  = 2'd2;
        end else begin
          w_ovf_evt = 1'b1;
        end
      end
      2'b01: begin
        if (r_cnt == 2'd2) begin
          w_head_next = r_tail;
          w_cnt_next  = 2'd1;
        end else begin
          w_cnt_next = 2'd0;
        end
      end
      2'b11: begin
        if (r_cnt == 2'd2) begin
          w_head_next = r_tail;
          w_tail_next = w_new;
        end else begin
          w_head_next = w_new;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge aud_mclk or posedge aud_mrst) begin
    if (aud_mrst) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_cnt   <= 2'd0;
      r_valid <= 1'b0;
    end else begin
      r_head  <= w_head_next;
      r_tail  <= w_tail_next;
      r_cnt   <= w_cnt_next;
      r_valid <= (w_cnt_next != 2'd0);
    end
  end

  // Sticky error flags; a new event outranks a simultaneous clear.
  always_ff @(posedge aud_mclk or posedge aud_mrst) begin
    if (aud_mrst) begin
      r_overflow  <= 1'b0;
      r_frame_err <= 1'b0;
      r_irq       <= 1'b0;
    end else begin
      r_overflow  <= w_ovf_evt | (r_overflow & ~err_clr);
      r_frame_err <= w_frame_evt | (r_frame_err & ~err_clr);
      r_irq       <= r_overflow | r_frame_err;
    end
  end

  assign m_axis.m_axis_tdata  = r_head.data;
  assign m_axis.m_axis_tid    = r_head.id;
  assign m_axis.m_axis_tvalid = r_valid;
  assign overflow             = r_overflow;
  assign frame_err            = r_frame_err;
  assign irq                  = r_irq;

endmodule

// File: doc/i2s_rx_10xe_deser.md
Name: i2s_rx_10xe_deser

Overview:
- I2S receiver (deserializer) for the serial audio stream produced by the I2S transmitter: sclk / lrclk / serial data in, parallel samples out.
- Oversamples all three serial inputs in the aud_mclk domain and recovers I2S framing (one-bit delay, MSB first, lrclk low = left).
- Pushes each completed sample into a 2-entry output FIFO drained by an AXI-Stream-style valid/ready master port.
- Used as the bench-side loopback checker of the transmitter and as a reusable RX datapath.

Parameters:
- DATA_WIDTH, 24: captured sample width, 8..32.
- SLOT_WIDTH, 32: sclk periods per channel slot, >= DATA_WIDTH+1.
- SYNC_STAGES, 2: synchronizer flops per serial input, >= 2.

Ports:
- aud_mclk  in  1  master audio clock; only clock in the block.
- aud_mrst  in  1  reset, asynchronous, active-high.
- rx_enable  in  1  receiver enable, level.
- sclk_in  in  1  serial bit clock, asynchronous to aud_mclk.
- lrclk_in  in  1  word select; 0 = left, 1 = right.
- sdata_0_in  in  1  serial data.
- m_axis_tdata  out  DATA_WIDTH  sample, MSB-aligned as received.
- m_axis_tid  out  1  channel: 0 = left, 1 = right.
- m_axis_tvalid  out  1  FIFO non-empty.
- m_axis_tready  in  1  sink ready.
- err_clr  in  1  single-cycle pulse; clears sticky error flags.
- overflow  out  1  sticky: a sample was dropped because the FIFO was full.
- frame_err  out  1  sticky: slot length was not SLOT_WIDTH.
- irq  out  1  registered (overflow | frame_err).

Behaviour:
- Reset: all outputs 0; FIFO empty; shift register, rise counter and channel register cleared; FSM = DISABLED.
- Synchronizers:
  - sclk_in, lrclk_in and sdata_0_in each pass through SYNC_STAGES flops.
  - A sclk rise is detected when synced sclk = 1 and the previous synced value = 0, giving a one-cycle "rise" strobe.
  - aud_mclk must be >= 4x the sclk frequency.
- Per rise: sample lrclk (ws) and sdata; ws_prev holds the ws sampled at the previous rise.
- Rise counter rc, saturating at 63:
  - On a rise with ws != ws_prev: rc := 1 and chan := ws. This rise carries the LSB of the previous slot.
  - On any other rise: rc := rc + 1.
  - Data: rises at which rc becomes 2..DATA_WIDTH+1 shift sdata in MSB first. Later bits in the slot are ignored.
- FSM:
  - DISABLED: no capture. rx_enable=1 -> WAIT_SYNC.
  - WAIT_SYNC: discards all data until the first rise with ws != ws_prev, then -> RUN. This ensures no partial first word.
  - RUN: capture active. When rc becomes DATA_WIDTH+1, push {chan, shift} into the FIFO on the next aud_mclk edge (push latency 1 cycle after the rise strobe).
  - rx_enable=0 in any state -> DISABLED on the next edge; the in-progress word is discarded. FIFO contents are retained and stay drainable.
- Frame check (RUN only): on a ws-change rise, rc before reload must equal SLOT_WIDTH, else frame_err := 1. Capture of the new slot proceeds normally (resync).
- FIFO:
  - Depth 2.
  - m_axis_tvalid = not empty; tdata/tid driven from the head entry.
  - Pop on tvalid & tready.
  - Push when full without a same-cycle pop: new sample dropped, overflow := 1, FIFO unchanged.
  - Push and pop in the same cycle while full: both occur, no overflow.
  - tdata/tid stable while tvalid=1 and tready=0.
- Errors:
  - err_clr clears overflow and frame_err.
  - A new error event in the same cycle as err_clr wins (flag stays 1).
  - irq follows the flags with 1 cycle latency.
- Reset asserted mid-word: immediate return to reset values. After release, the block requires rx_enable and a fresh ws change before capturing.

Test Plan:
- Nominal stereo: sclk = mclk/8, SLOT_WIDTH=32, left 0xA5A5A5, right 0x5A5A5A, tready=1 -> beats (tid0, 0xA5A5A5) then (tid1, 0x5A5A5A); each beat 1 cycle after the 25th-rise strobe; no flags.
- Backpressure: tready=0 for 3 samples 0x111111, 0x222222, 0x333333 -> FIFO holds the first two; third dropped; overflow=1, irq=1 one cycle later. Release tready -> 0x111111 then 0x222222. err_clr -> overflow=0, irq=0.
- Full with simultaneous pop/push: FIFO full, tready=1 on the exact push cycle -> head popped, new sample stored, overflow stays 0.
- Short slot: lrclk toggles after 30 rises -> frame_err=1 at that rise. Next slot 0x0F0F0F is still delivered intact.
- Mid-slot enable: rx_enable raised at rise 10 of a left slot -> partial word discarded; first beat is the following right slot.
- Reset mid-word: aud_mrst pulsed at rise 12 with 1 entry in the FIFO -> tvalid=0, flags=0 immediately; the next output beat comes only after a new ws change plus DATA_WIDTH bits.
